// File: rtl/bcast_sched_pkg.sv
// Shared types and sizing constants for the broadcast scheduler.
package bcast_sched_pkg;

  localparam int unsigned CH_NUM            = 4;
  localparam int unsigned BCAST_PIPE_LENGTH = 4;

  // Order FIFO fields are sized for the widest supported requester ID and tag.
  localparam int unsigned BSCHED_ID_W  = 8;
  localparam int unsigned BSCHED_TAG_W = 16;

  typedef enum logic {
    IDLE,
    ISSUE
  } bsched_state_t;

  typedef struct packed {
    logic [BSCHED_ID_W-1:0]  req_id;
    logic [BSCHED_TAG_W-1:0] tag;
  } bsched_ord_t;

endpackage

// File: rtl/bcast_sched_rr_arbiter.sv
// Round-robin arbiter: priority starts at the requester after the last winner.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = PW'((32'(idx) + 1) % N);
      end
    end
    if (!advance) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bcast_sched.sv
// Broadcast scheduler: arbitrates requests, issues them to channels, and returns
// in-order completions as the collector retires broadcasts.
module bcast_sched
  import bcast_sched_pkg::*;
#(
  parameter int unsigned REQ_NUM = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQ_NUM-1:0]              req_valid,
  output logic [REQ_NUM-1:0]              req_ready,
  input  logic [REQ_NUM-1:0][CH_NUM-1:0]  req_mask,
  input  logic [REQ_NUM-1:0][TAG_W-1:0]   req_tag,
  output logic [CH_NUM-1:0]               ch_issue_valid,
  input  logic [CH_NUM-1:0]               ch_issue_ready,
  output logic                            bcast_add,
  output logic [CH_NUM-1:0]               bcast_mask,
  input  logic                            bcast_pipe_full,
  input  logic                            bcast_resp,
  output logic                            bcast_pull,
  output logic                            cpl_valid,
  output logic [$clog2(REQ_NUM)-1:0]      cpl_req_id,
  output logic [TAG_W-1:0]                cpl_tag,
  input  logic                            cpl_ready
);

  localparam int unsigned ID_W  = $clog2(REQ_NUM);
  localparam int unsigned PTR_W = $clog2(BCAST_PIPE_LENGTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bsched_state_t     state_q, state_d;
  logic [CH_NUM-1:0] issue_mask_q, issue_mask_d;
  logic [CH_NUM-1:0] acc_q, acc_d;
  logic [CH_NUM-1:0] accepted;
  logic              issue_done;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  bsched_ord_t       fifo_q [BCAST_PIPE_LENGTH];
  bsched_ord_t       ord_in;
  bsched_ord_t       cpl_q;
  logic              cpl_valid_q;

  logic               grant_ok;
  logic [REQ_NUM-1:0] arb_req;
  logic [REQ_NUM-1:0] grant;
  logic [ID_W-1:0]    win_id;

  // out_cnt is registered, so a pull only frees a slot for the following cycle.
  assign grant_ok = rst_n && (state_q == IDLE) && !bcast_pipe_full &&
                    (out_cnt_q < CNT_W'(BCAST_PIPE_LENGTH));
  assign arb_req  = req_valid & {REQ_NUM{grant_ok}};

  rr_arbiter #(
    .N (REQ_NUM)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (bcast_add),
    .grant   (grant)
  );

  always_comb begin
    win_id = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  assign req_ready  = grant;
  assign bcast_add  = |grant;
  assign bcast_mask = bcast_add ? req_mask[win_id] : '0;

  assign ord_in.req_id = BSCHED_ID_W'(win_id);
  assign ord_in.tag    = BSCHED_TAG_W'(req_tag[win_id]);

  assign ch_issue_valid = (state_q == ISSUE) ? (issue_mask_q & ~acc_q) : '0;
  assign accepted       = ch_issue_valid & ch_issue_ready;
  assign issue_done     = ((acc_q | accepted) == issue_mask_q);

  assign bcast_pull = rst_n && bcast_resp && (out_cnt_q != '0) && (!cpl_valid_q || cpl_ready);

  always_comb begin
    state_d      = state_q;
    issue_mask_d = issue_mask_q;
    acc_d        = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bcast_add) begin
          state_d      = ISSUE;
          issue_mask_d = bcast_mask;
          acc_d        = '0;
        end
      end
      ISSUE: begin
        acc_d = acc_q | accepted;
        if (issue_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case ({bcast_add, bcast_pull})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      issue_mask_q <= '0;
      acc_q        <= '0;
      out_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cpl_q        <= '0;
      cpl_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_mask_q <= issue_mask_d;
      acc_q        <= acc_d;
      out_cnt_q    <= out_cnt_d;
      if (bcast_add) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (bcast_pull) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        cpl_q       <= fifo_q[rd_ptr_q];
        cpl_valid_q <= 1'b1;
      end else if (cpl_ready) begin
        cpl_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bcast_add) begin
      fifo_q[wr_ptr_q] <= ord_in;
    end
  end

  assign cpl_valid  = cpl_valid_q;
  assign cpl_req_id = ID_W'(cpl_q.req_id);
  assign cpl_tag    = TAG_W'(cpl_q.tag);

endmodule

// File: tb/tb_bcast_sched.sv
// Directed bench for bcast_sched; completions are checked by a scoreboard monitor.
module tb_bcast_sched;
  import bcast_sched_pkg::*;

  localparam int unsigned REQ_NUM = 2;
  localparam int unsigned TAG_W   = 4;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [REQ_NUM-1:0]             req_valid;
  logic [REQ_NUM-1:0]             req_ready;
  logic [REQ_NUM-1:0][CH_NUM-1:0] req_mask;
  logic [REQ_NUM-1:0][TAG_W-1:0]  req_tag;
  logic [CH_NUM-1:0]              ch_issue_valid;
  logic [CH_NUM-1:0]              ch_issue_ready;
  logic                           bcast_add;
  logic [CH_NUM-1:0]              bcast_mask;
  logic                           bcast_pipe_full;
  logic                           bcast_resp;
  logic                           bcast_pull;
  logic                           cpl_valid;
  logic [$clog2(REQ_NUM)-1:0]     cpl_req_id;
  logic [TAG_W-1:0]               cpl_tag;
  logic                           cpl_ready;

  bcast_sched #(
    .REQ_NUM (REQ_NUM),
    .TAG_W   (TAG_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_mask        (req_mask),
    .req_tag         (req_tag),
    .ch_issue_valid  (ch_issue_valid),
    .ch_issue_ready  (ch_issue_ready),
    .bcast_add       (bcast_add),
    .bcast_mask      (bcast_mask),
    .bcast_pipe_full (bcast_pipe_full),
    .bcast_resp      (bcast_resp),
    .bcast_pull      (bcast_pull),
    .cpl_valid       (cpl_valid),
    .cpl_req_id      (cpl_req_id),
    .cpl_tag         (cpl_tag),
    .cpl_ready       (cpl_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input int id, input int tag);
    exp_t e;
    e.id  = id;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst_n      = 1'b0;
    req_valid  = '0;
    bcast_resp = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every consumed completion must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && cpl_valid === 1'b1 && cpl_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("cpl_unexpected_qsize", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("cpl_req_id", int'(cpl_req_id), e.id);
        chk("cpl_tag", int'(cpl_tag), e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    req_valid       = '0;
    req_mask        = '0;
    req_tag         = '0;
    ch_issue_ready  = '1;
    bcast_pipe_full = 1'b0;
    bcast_resp      = 1'b0;
    cpl_ready       = 1'b1;
    repeat (3) cyc();
    smp();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_ch_issue_valid", int'(ch_issue_valid), 0);
    chk("rst_bcast_add", int'(bcast_add), 0);
    chk("rst_bcast_mask", int'(bcast_mask), 0);
    chk("rst_bcast_pull", int'(bcast_pull), 0);
    chk("rst_cpl_valid", int'(cpl_valid), 0);
    cyc();
    rst_n = 1'b1;

    // Single request, channels ready immediately.
    cyc();
    req_valid   = 2'b01;
    req_mask[0] = 4'h5;
    req_tag[0]  = 4'h3;
    smp();
    chk("t1_req_ready", int'(req_ready), 1);
    chk("t1_bcast_add", int'(bcast_add), 1);
    chk("t1_bcast_mask", int'(bcast_mask), 5);
    push(0, 3);
    cyc();
    req_valid = '0;
    smp();
    chk("t1_issue_valid", int'(ch_issue_valid), 5);
    chk("t1_add_pulse", int'(bcast_add), 0);
    repeat (3) cyc();
    cyc();
    bcast_resp = 1'b1;
    smp();
    chk("t1_pull", int'(bcast_pull), 1);
    chk("t1_cpl_not_yet", int'(cpl_valid), 0);
    cyc();
    bcast_resp = 1'b0;
    smp();
    chk("t1_cpl_valid", int'(cpl_valid), 1);

    // Both requesters valid: alternating grants, then pipe full.
    do_reset();
    req_mask[0] = 4'h3;
    req_mask[1] = 4'hC;
    for (int g = 0; g < 4; g++) begin
      cyc();
      req_valid      = 2'b11;
      req_tag[g % 2] = 4'(g + 1);
      smp();
      chk("t2_grant", int'(req_ready), 1 << (g % 2));
      chk("t2_add_mask", int'(bcast_mask), (g % 2) ? 12 : 3);
      push(g % 2, g + 1);
      cyc();
      smp();
      chk("t2_issue_valid", int'(ch_issue_valid), (g % 2) ? 12 : 3);
      chk("t2_no_grant_in_issue", int'(req_ready), 0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      smp();
      chk("full_no_grant", int'(req_ready), 0);
    end
    cyc();
    bcast_resp = 1'b1;
    smp();
    chk("full_pull", int'(bcast_pull), 1);
    chk("full_no_grant_pull_cycle", int'(req_ready), 0);
    cyc();
    bcast_resp = 1'b0;
    smp();
    chk("full_regrant", int'(req_ready), 1);
    chk("full_cpl_valid", int'(cpl_valid), 1);
    push(0, 3);
    cyc();
    req_valid = '0;
    smp();
    chk("regrant_issue_valid", int'(ch_issue_valid), 3);

    // Completion back-pressure, then back-to-back pulls.
    cyc();
    cpl_ready  = 1'b0;
    bcast_resp = 1'b1;
    smp();
    chk("hold_first_pull", int'(bcast_pull), 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      smp();
      chk("hold_pull", int'(bcast_pull), 0);
      chk("hold_cpl_valid", int'(cpl_valid), 1);
      chk("hold_cpl_tag", int'(cpl_tag), 2);
      chk("hold_cpl_id", int'(cpl_req_id), 1);
    end
    cyc();
    cpl_ready = 1'b1;
    smp();
    chk("b2b_pull0", int'(bcast_pull), 1);
    cyc();
    smp();
    chk("b2b_pull1", int'(bcast_pull), 1);
    chk("b2b_cpl_valid1", int'(cpl_valid), 1);
    cyc();
    smp();
    chk("b2b_pull2", int'(bcast_pull), 1);
    chk("b2b_cpl_valid2", int'(cpl_valid), 1);
    cyc();
    smp();
    chk("empty_no_pull", int'(bcast_pull), 0);
    chk("b2b_cpl_valid3", int'(cpl_valid), 1);
    cyc();
    bcast_resp = 1'b0;
    smp();
    chk("drain_qsize", exp_q.size(), 0);
    chk("drain_cpl_valid", int'(cpl_valid), 0);

    // Channel 2 stalls for 10 cycles with a full mask.
    cyc();
    req_valid      = 2'b10;
    req_mask[1]    = 4'hF;
    req_tag[1]     = 4'h7;
    ch_issue_ready = 4'hB;
    smp();
    chk("t3_grant", int'(req_ready), 2);
    push(1, 7);
    cyc();
    req_valid = 2'b01;
    smp();
    chk("t3_first_issue", int'(ch_issue_valid), 15);
    chk("t3_first_no_grant", int'(req_ready), 0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      smp();
      chk("t3_stall_valid", int'(ch_issue_valid), 4);
      chk("t3_stall_no_grant", int'(req_ready), 0);
    end
    cyc();
    ch_issue_ready = 4'hF;
    smp();
    chk("t3_last_valid", int'(ch_issue_valid), 4);
    chk("t3_last_no_grant", int'(req_ready), 0);
    cyc();
    smp();
    chk("t3_done_valid", int'(ch_issue_valid), 0);
    chk("t3_next_grant", int'(req_ready), 1);
    push(0, 3);
    cyc();
    req_valid = '0;
    smp();
    chk("t3_next_issue", int'(ch_issue_valid), 3);
    cyc();
    bcast_resp = 1'b1;
    smp();
    chk("t3_pull0", int'(bcast_pull), 1);
    cyc();
    smp();
    chk("t3_pull1", int'(bcast_pull), 1);
    cyc();
    bcast_resp = 1'b0;
    smp();
    cyc();
    smp();
    chk("t3_qsize", exp_q.size(), 0);

    // Zero-mask broadcast, then reset during a stalled issue.
    cyc();
    req_valid   = 2'b01;
    req_mask[0] = 4'h0;
    req_tag[0]  = 4'h5;
    smp();
    chk("z_grant", int'(req_ready), 1);
    chk("z_add", int'(bcast_add), 1);
    chk("z_mask", int'(bcast_mask), 0);
    cyc();
    req_mask[0]    = 4'h1;
    ch_issue_ready = 4'h0;
    smp();
    chk("z_issue_valid", int'(ch_issue_valid), 0);
    chk("z_issue_no_grant", int'(req_ready), 0);
    cyc();
    smp();
    chk("z_second_grant", int'(req_ready), 1);
    chk("z_second_mask", int'(bcast_mask), 1);
    cyc();
    req_valid = '0;
    smp();
    chk("stall_valid0", int'(ch_issue_valid), 1);
    cyc();
    smp();
    chk("stall_valid1", int'(ch_issue_valid), 1);
    cyc();
    rst_n = 1'b0;
    cyc();
    smp();
    chk("mid_rst_issue_valid", int'(ch_issue_valid), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    chk("mid_rst_add", int'(bcast_add), 0);
    chk("mid_rst_cpl_valid", int'(cpl_valid), 0);
    cyc();
    rst_n      = 1'b1;
    bcast_resp = 1'b1;
    smp();
    chk("post_rst_pull_cnt0", int'(bcast_pull), 0);
    chk("post_rst_issue_valid", int'(ch_issue_valid), 0);
    cyc();
    bcast_resp     = 1'b0;
    ch_issue_ready = '1;

    // Collector-full input blocks grants.
    cyc();
    bcast_pipe_full = 1'b1;
    req_valid       = 2'b01;
    req_mask[0]     = 4'h2;
    smp();
    chk("pfull_no_grant", int'(req_ready), 0);
    cyc();
    bcast_pipe_full = 1'b0;
    smp();
    chk("pfull_release_grant", int'(req_ready), 1);
    cyc();
    req_valid = '0;
    smp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcast_sched.md
# bcast_sched

Broadcast scheduler in front of the broadcast response collector. It round-robin arbitrates broadcast requests from `REQ_NUM` requesters and issues each granted broadcast to its masked channels through per-channel valid/ready. It registers the broadcast with the collector (`bcast_add`/`bcast_mask`), pulls completed broadcasts in order (`bcast_pull`), and returns an in-order completion carrying requester ID and tag.

## Interface
- `REQ_NUM`, 2: number of requesters (≥2).
- `TAG_W`, 4: requester tag width.
- `CH_NUM`, package constant: channel count.
- `BCAST_PIPE_LENGTH`, package constant: maximum in-flight broadcasts (power of 2).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in [REQ_NUM]: request pending.
- `req_ready` out [REQ_NUM]: one-hot grant; a handshake occurs when `req_valid & req_ready`.
- `req_mask` in [REQ_NUM][CH_NUM]: participating channels.
- `req_tag` in [REQ_NUM][TAG_W]: opaque tag, returned on completion.
- `ch_issue_valid` out [CH_NUM]: broadcast command offered to the channel.
- `ch_issue_ready` in [CH_NUM]: the channel accepts the command.
- `bcast_add` out 1: one-cycle pulse registering a new broadcast with the collector.
- `bcast_mask` out [CH_NUM]: mask of the broadcast being added; valid only with `bcast_add`, 0 otherwise.
- `bcast_pipe_full` in 1: collector holds `BCAST_PIPE_LENGTH` broadcasts.
- `bcast_resp` in 1: collector reports that the oldest outstanding broadcast is complete.
- `bcast_pull` out 1: removes the oldest broadcast from the collector.
- `cpl_valid` out 1: completion available.
- `cpl_req_id` out [$clog2(REQ_NUM)]: requester ID of the completed broadcast.
- `cpl_tag` out [TAG_W]: tag of the completed broadcast.
- `cpl_ready` in 1: completion consumed.

## Operation
- FSM has two states:
  - IDLE → ISSUE when any `req_valid` and grant is allowed.
  - ISSUE → IDLE when the issue is done.
- Grant is allowed only in IDLE, with `!bcast_pipe_full` and `out_cnt < BCAST_PIPE_LENGTH`.
- Arbitration: round-robin. Priority starts at the index after the last granted requester; after reset, requester 0 has top priority. `req_ready` is asserted only for the winner and only in the grant cycle.
- Grant cycle actions:
  - `bcast_add`=1 and `bcast_mask`=`req_mask[winner]`.
  - Mask latched into `issue_mask`; `acc` cleared.
  - {winner, tag} pushed to the order FIFO (depth `BCAST_PIPE_LENGTH`).
  - `out_cnt`+1.
- ISSUE: `ch_issue_valid` = `issue_mask & ~acc`. Each cycle, `acc |= ch_issue_valid & ch_issue_ready`.
- Issue done when `(acc | (ch_issue_valid & ch_issue_ready)) == issue_mask`.
- Zero mask: ISSUE lasts exactly one cycle with no valids; the collector sees the broadcast as complete immediately.
- Pull: `bcast_pull` = `bcast_resp && out_cnt!=0 && (!cpl_valid || cpl_ready)`. On pull, the FIFO pops into the completion register and `out_cnt`−1.
- Simultaneous add and pull: `out_cnt` unchanged; FIFO push and pop are both performed.
- Completion register holds its value while `cpl_valid && !cpl_ready`.

## Timing
- Reset values: all outputs 0, FSM IDLE, `out_cnt`=0, FIFO empty, RR pointer = requester 0.
- Reset during ISSUE drops `ch_issue_valid` the next cycle. The collector is reset in the same cycle by the integrator.
- Grant to first `ch_issue_valid`: 1 cycle.
- Best-case request rate: one grant per 2 cycles (grant, ISSUE done, grant).
- `bcast_add` precedes any channel acceptance by ≥1 cycle, so collector mask bits are preset before responses.
- `bcast_pull` is combinational from `bcast_resp`/`cpl_ready`.
- `cpl_valid` rises the cycle after `bcast_pull`.
- Back-to-back pulls are allowed when `cpl_ready`=1: one completion per cycle.
- `ch_issue_valid` for a channel never deasserts before acceptance. It is removed the cycle after `ch_issue_ready`.
- Full: at `out_cnt==BCAST_PIPE_LENGTH` or `bcast_pipe_full`, no `req_ready`. A pull in the same cycle does not unblock the grant until the next cycle.
- FIFO pointers are `$clog2(BCAST_PIPE_LENGTH)` bits and wrap naturally. `out_cnt` is one bit wider.

## Structure
- `aimc_lib` gains:
  - `bsched_state_t` enum {IDLE, ISSUE}.
  - `bsched_ord_t` struct {req_id, tag}.
  - Constants `CH_NUM` and `BCAST_PIPE_LENGTH`, reused from the package.
- Sub-module `rr_arbiter`, parameterized by N: request vector, advance strobe, one-hot grant, registered pointer.
- Order FIFO, issue tracking and completion register stay inline.

## Test plan
- Single request from req0, mask=0x5, channels ready immediately → `bcast_add`=1 with mask 0x5 at t; `ch_issue_valid`=0x5 at t+1; `bcast_resp` at t+5 → `bcast_pull` at t+5; `cpl_valid` with id 0 and tag 3 at t+6.
- Both requesters continuously valid, 4 grants → grant order 0,1,0,1. Tags return in issue order.
- Channel 2 holds `ch_issue_ready`=0 for 10 cycles, mask=0xF → channels 0,1,3 are accepted at t+1; ISSUE stays 11 cycles; no second grant during ISSUE.
- Fill `BCAST_PIPE_LENGTH` broadcasts without responses → `req_ready` stays 0. One pull restores a grant exactly one cycle later.
- `cpl_ready`=0 with two completed broadcasts → the first completion is held and `bcast_pull` stays 0. `cpl_ready`=1 → completions are returned in consecutive cycles.
- Zero mask, then `rst_n`=0 during a stalled ISSUE → zero mask: one ISSUE cycle with no valids. Reset: all outputs 0 the next cycle and `out_cnt`=0.
